// File: rtl/vga_timing_gen_if.sv
// VGA timing bundle: pixel/line counters plus sync and blanking flags.
// The producer drives it through modport out (alias master); consumers use in (alias slave).
interface vga_if_tim;
   logic [10:0] vcount;
   logic [10:0] hcount;
   logic        hsync;
   logic        vsync;
   logic        hblnk;
   logic        vblnk;

   modport out (output vcount, hcount, hsync, vsync, hblnk, vblnk);
   modport in  (input  vcount, hcount, hsync, vsync, hblnk, vblnk);

   modport master (output vcount, hcount, hsync, vsync, hblnk, vblnk);
   modport slave  (input  vcount, hcount, hsync, vsync, hblnk, vblnk);
endinterface

// File: rtl/vga_timing_gen.sv
// VGA timing generator with frame-start pulse, frame counter and a latched game-state vector.
// Define VGA_TIM_SAFE_SWITCH_EN to reload state_bin_out only at frame boundaries.
module vga_timing_gen #(
   parameter int H_ACTIVE = 800,
   parameter int H_FP     = 40,
   parameter int H_SYNC   = 128,
   parameter int H_BP     = 88,
   parameter int V_ACTIVE = 600,
   parameter int V_FP     = 1,
   parameter int V_SYNC   = 4,
   parameter int V_BP     = 23,
   parameter int SYNC_POL = 1
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [5:0]  state_bin_in,
   output logic [5:0]  state_bin_out,
   output logic        frame_start,
   output logic [15:0] frame_cnt,
   vga_if_tim.out      tim_if_out
);

   localparam logic [10:0] H_LAST   = 11'(H_ACTIVE + H_FP + H_SYNC + H_BP - 1);
   localparam logic [10:0] V_LAST   = 11'(V_ACTIVE + V_FP + V_SYNC + V_BP - 1);
   localparam logic [10:0] H_ACT_C  = 11'(H_ACTIVE);
   localparam logic [10:0] V_ACT_C  = 11'(V_ACTIVE);
   localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FP);
   localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FP + H_SYNC);
   localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FP);
   localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FP + V_SYNC);
   localparam logic        SYNC_ON  = (SYNC_POL != 0);

   logic [10:0] hcount_reg, vcount_reg;
   logic [10:0] hcount_next, vcount_next;
   logic        hsync_reg, vsync_reg, hblnk_reg, vblnk_reg;
   logic        run_reg;
   logic        frame_start_reg;
   logic [15:0] frame_cnt_reg;
   logic [5:0]  state_reg;
   logic        h_wrap, v_wrap, frame_wrap;
   logic        state_valid, state_load;

   // run_reg holds the counters at (0,0) for the first cycle after reset,
   // so that post-reset origin never looks like a frame wrap.
   always_comb begin
      h_wrap      = (hcount_reg == H_LAST);
      v_wrap      = (vcount_reg == V_LAST);
      frame_wrap  = run_reg && h_wrap && v_wrap;
      hcount_next = hcount_reg;
      vcount_next = vcount_reg;
      if (run_reg) begin
         hcount_next = h_wrap ? 11'd0 : hcount_reg + 11'd1;
         if (h_wrap)
            vcount_next = v_wrap ? 11'd0 : vcount_reg + 11'd1;
      end
      state_valid = (state_bin_in != 6'd0) &&
                    ((state_bin_in & (state_bin_in - 6'd1)) == 6'd0);
`ifdef VGA_TIM_SAFE_SWITCH_EN
      state_load  = frame_wrap && state_valid;
`else
      state_load  = state_valid;
`endif
   end

   // Flags are derived from the next counter values so they line up with the counters.
   always_ff @(posedge clk) begin
      if (rst) begin
         run_reg         <= 1'b0;
         hcount_reg      <= 11'd0;
         vcount_reg      <= 11'd0;
         hblnk_reg       <= 1'b0;
         vblnk_reg       <= 1'b0;
         hsync_reg       <= ~SYNC_ON;
         vsync_reg       <= ~SYNC_ON;
         frame_start_reg <= 1'b0;
         frame_cnt_reg   <= 16'd0;
         state_reg       <= 6'b000001;
      end else begin
         run_reg         <= 1'b1;
         hcount_reg      <= hcount_next;
         vcount_reg      <= vcount_next;
         hblnk_reg       <= (hcount_next >= H_ACT_C);
         vblnk_reg       <= (vcount_next >= V_ACT_C);
         hsync_reg       <= ((hcount_next >= HS_START) && (hcount_next < HS_END)) ? SYNC_ON : ~SYNC_ON;
         vsync_reg       <= ((vcount_next >= VS_START) && (vcount_next < VS_END)) ? SYNC_ON : ~SYNC_ON;
         frame_start_reg <= frame_wrap;
         if (frame_wrap)
            frame_cnt_reg <= frame_cnt_reg + 16'd1;
         if (state_load)
            state_reg <= state_bin_in;
      end
   end

   assign tim_if_out.hcount = hcount_reg;
   assign tim_if_out.vcount = vcount_reg;
   assign tim_if_out.hsync  = hsync_reg;
   assign tim_if_out.vsync  = vsync_reg;
   assign tim_if_out.hblnk  = hblnk_reg;
   assign tim_if_out.vblnk  = vblnk_reg;
   assign frame_start       = frame_start_reg;
   assign frame_cnt         = frame_cnt_reg;
   assign state_bin_out     = state_reg;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Randomized scoreboard bench for vga_timing_gen using a shrunken raster so several frames fit in a short run.
// Expected outputs come from the raster position computed arithmetically from the clock count since reset.
module tb_vga_timing_gen;

   localparam int H_ACTIVE = 16;
   localparam int H_FP     = 4;
   localparam int H_SYNC   = 8;
   localparam int H_BP     = 4;
   localparam int V_ACTIVE = 12;
   localparam int V_FP     = 1;
   localparam int V_SYNC   = 2;
   localparam int V_BP     = 3;
   localparam int SYNC_POL = 1;
   localparam int HT = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int VT = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int FT = HT * VT;

   typedef struct packed {
      logic [10:0] h;
      logic [10:0] v;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic        fs;
      logic [15:0] fc;
      logic [5:0]  st;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [5:0]  state_bin_in = 6'b000001;
   logic [5:0]  state_bin_out;
   logic        frame_start;
   logic [15:0] frame_cnt;

   vga_if_tim tim ();

   vga_timing_gen #(
      .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
      .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
      .SYNC_POL(SYNC_POL)
   ) dut (
      .clk(clk),
      .rst(rst),
      .state_bin_in(state_bin_in),
      .state_bin_out(state_bin_out),
      .frame_start(frame_start),
      .frame_cnt(frame_cnt),
      .tim_if_out(tim)
   );

   always #5 clk = ~clk;

   exp_t exp_q[$];
   int   compared   = 0;
   int   mismatched = 0;
   int   cycle_no   = 0;
   int   adv        = -1;
   int   exp_pulses = 0;
   int   got_pulses = 0;
   logic [5:0] st_model = 6'b000001;

   function automatic logic is_onehot(input logic [5:0] x);
      int n = 0;
      for (int i = 0; i < 6; i++) if (x[i]) n++;
      return (n == 1);
   endfunction

   // Raster outputs for a given number of advancing clocks since reset.
   function automatic exp_t raster(input int p);
      exp_t e;
      int h, v;
      logic on;
      on = (SYNC_POL != 0);
      h = p % HT;
      v = (p / HT) % VT;
      e.h  = 11'(h);
      e.v  = 11'(v);
      e.hb = (h >= H_ACTIVE);
      e.vb = (v >= V_ACTIVE);
      e.hs = (h >= H_ACTIVE + H_FP && h < H_ACTIVE + H_FP + H_SYNC) ? on : ~on;
      e.vs = (v >= V_ACTIVE + V_FP && v < V_ACTIVE + V_FP + V_SYNC) ? on : ~on;
      e.fs = (p > 0) && (p % FT == 0);
      e.fc = 16'((p / FT) % 65536);
      e.st = 6'b000001;
      return e;
   endfunction

   function automatic int cur_pos();
      return (adv < 0) ? 0 : adv;
   endfunction

   // Drive one cycle of inputs, predict the state after the next edge, queue it.
   task automatic step(input logic r);
      exp_t e;
      rst = r;
      if ($urandom_range(0, 39) == 0) begin
         if ($urandom_range(0, 3) != 0)
            state_bin_in = 6'(6'b000001 << $urandom_range(0, 5));
         else
            state_bin_in = 6'($urandom);
      end
      if (r) adv = -1;
      else adv++;
      e = raster(cur_pos());
      if (r)
         st_model = 6'b000001;
`ifdef VGA_TIM_SAFE_SWITCH_EN
      else if (e.fs && is_onehot(state_bin_in))
         st_model = state_bin_in;
`else
      else if (is_onehot(state_bin_in))
         st_model = state_bin_in;
`endif
      e.st = st_model;
      if (e.fs) exp_pulses++;
      exp_q.push_back(e);
      @(negedge clk);
   endtask

   // Monitor: every clock presents a fresh output sample; compare it with the oldest prediction.
   initial begin
      exp_t e;
      forever begin
         @(posedge clk);
         #2;
         if (exp_q.size() > 0) begin
            e = exp_q.pop_front();
            cycle_no++;
            compared++;
            if (frame_start) got_pulses++;
            if (tim.hcount !== e.h || tim.vcount !== e.v || tim.hsync !== e.hs ||
                tim.vsync !== e.vs || tim.hblnk !== e.hb || tim.vblnk !== e.vb ||
                frame_start !== e.fs || frame_cnt !== e.fc || state_bin_out !== e.st) begin
               mismatched++;
               $display("FAIL cycle%0d outputs: got h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d st=%b required h=%0d v=%0d hs=%b vs=%b hb=%b vb=%b fs=%b fc=%0d st=%b",
                        cycle_no, tim.hcount, tim.vcount, tim.hsync, tim.vsync, tim.hblnk,
                        tim.vblnk, frame_start, frame_cnt, state_bin_out,
                        e.h, e.v, e.hs, e.vs, e.hb, e.vb, e.fs, e.fc, e.st);
            end
         end
      end
   end

   initial begin
      int  p;
      bit  found;
      for (int i = 0; i < 5; i++) step(1'b1);
      for (int i = 0; i < 2 * FT + 40; i++) step(1'b0);

      // Reset while vsync is active, mid-line.
      found = 1'b0;
      for (int i = 0; i < FT + 1 && !found; i++) begin
         p = cur_pos() + 1;
         if ((p % HT) == H_ACTIVE / 2 && ((p / HT) % VT) == V_ACTIVE + V_FP + 1)
            found = 1'b1;
         else
            step(1'b0);
      end
      compared++;
      if (!found) begin
         mismatched++;
         $display("FAIL seek_vsync: got not_found required found");
      end
      step(1'b0);
      step(1'b1);
      for (int i = 0; i < FT + 100; i++) step($urandom_range(0, 699) == 0);
      for (int i = 0; i < 3; i++) step(1'b1);
      for (int i = 0; i < 2 * HT; i++) step(1'b0);

      repeat (3) @(negedge clk);
      compared++;
      if (exp_q.size() != 0) begin
         mismatched++;
         $display("FAIL drain: got %0d pending required 0", exp_q.size());
      end
      compared++;
      if (got_pulses != exp_pulses || exp_pulses < 2) begin
         mismatched++;
         $display("FAIL pulse_count: got %0d required %0d (at least 2)", got_pulses, exp_pulses);
      end
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
   end

endmodule

// File: doc/vga_timing_gen.md
Name: vga_timing_gen

Overview:
- Produces the VGA timing stream (hcount, vcount, hsync, vsync, hblnk, vblnk) on a vga_if_tim.out port. This is the stream that the background selector and the draw blocks consume.
- Also publishes a per-frame start pulse and a frame counter.
- Also publishes a game-state vector that is re-latched only at frame boundaries, so background switching never tears mid-frame.
- Sits at the head of the video pipeline, directly after the pixel clock.

Parameters:
- H_ACTIVE, 800, visible pixels per line
- H_FP, 40, horizontal front porch (clocks)
- H_SYNC, 128, hsync width (clocks)
- H_BP, 88, horizontal back porch (clocks)
- V_ACTIVE, 600, visible lines per frame
- V_FP, 1, vertical front porch (lines)
- V_SYNC, 4, vsync width (lines)
- V_BP, 23, vertical back porch (lines)
- SYNC_POL, 1, sync active level (1 = active-high)

Ports:
- clk  in  1  pixel clock (40 MHz for defaults)
- rst  in  1  synchronous, active-high reset
- state_bin_in  in  6  one-hot game state from the control FSM
- state_bin_out  out  6  frame-aligned game state for the background selector
- frame_start  out  1  one-cycle pulse at pixel (0,0)
- frame_cnt  out  16  frames completed since reset, wraps
- tim_if_out  vga_if_tim.out  —  vcount[10:0], hcount[10:0], hsync, vsync, hblnk, vblnk

Behaviour:
- Interface: one clock, clk; reset rst is synchronous and active-high.
- Derived constants: H_TOTAL = H_ACTIVE+H_FP+H_SYNC+H_BP (1056); V_TOTAL = V_ACTIVE+V_FP+V_SYNC+V_BP (628).
- Counters:
  - hcount increments every clk; wraps H_TOTAL-1 → 0.
  - vcount increments when hcount wraps; wraps V_TOTAL-1 → 0 on the same edge.
- All outputs are registered. Flags are computed from the next counter values, so flags, hcount and vcount are mutually consistent in every cycle (zero skew between them).
- Flag windows, inclusive:
  - hblnk = 1 for hcount ≥ H_ACTIVE (800..1055).
  - hsync active for H_ACTIVE+H_FP ≤ hcount < H_ACTIVE+H_FP+H_SYNC (840..967).
  - vblnk = 1 for vcount ≥ V_ACTIVE (600..627).
  - vsync active for V_ACTIVE+V_FP ≤ vcount < V_ACTIVE+V_FP+V_SYNC (601..604).
  - Inactive sync level is !SYNC_POL.
- Reset values while rst = 1:
  - hcount = 0, vcount = 0, hblnk = 0, vblnk = 0.
  - hsync = vsync = !SYNC_POL.
  - frame_start = 0, frame_cnt = 0, state_bin_out = 6'b000001 (start screen).
- First clock after rst deasserts: counters hold (0,0) for exactly one cycle, then advance. frame_start is NOT pulsed for this post-reset (0,0).
- frame_start:
  - Asserts for the single cycle in which the counters wrap from (1055,627) to (0,0).
  - Exactly once per V_TOTAL*H_TOTAL clocks.
- frame_cnt: increments on the same edge that raises frame_start; 16'hFFFF → 16'h0000.
- state_bin_out:
  - Loads state_bin_in on the edge that raises frame_start. The new value is visible in the same cycle as frame_start and stays stable for the whole frame.
  - If state_bin_in is not one-hot (zero, or multiple bits set) at the load edge, state_bin_out holds its previous value.
- Reset mid-frame: all outputs return to their reset values on the next edge; no partial sync pulse is extended.

Optional Feature:
- Macro: VGA_TIM_SAFE_SWITCH_EN.
- Defined: state_bin_out updates only at frame_start, as described above.
- Undefined:
  - state_bin_out is state_bin_in registered every clk (1-cycle latency), with the same one-hot validity filter and the same reset value.
  - frame_start and frame_cnt are unchanged.

Test Plan:
- Reset: hold rst 5 cycles → all outputs at reset values, hcount = vcount = 0, state_bin_out = 6'b000001. Release rst → hcount = 0 for one more cycle, then 1.
- Line timing: run 1056 clocks from (0,0):
  - hblnk rises at hcount = 800.
  - hsync = 1 exactly for hcount 840..967 (128 cycles).
  - vcount = 1 when hcount returns to 0.
- Frame timing: run 2 full frames (2×663168 clocks):
  - vsync high only on lines 601..604; vblnk only on lines 600..627.
  - frame_start pulses exactly twice, each in a cycle with hcount = vcount = 0.
  - frame_cnt = 2.
- Safe switch (macro defined):
  - Change state_bin_in 000001 → 000010 at (400,300) → state_bin_out stays 000001 until the next frame_start, then reads 000010.
  - Apply 000110 before the following frame → state_bin_out stays 000010.
- Reset mid-frame: assert rst at (500,602) while vsync is active → next cycle vsync = 0, counters = 0, frame_cnt = 0, state_bin_out = 000001.
- frame_cnt wrap: force frame_cnt to 16'hFFFF, run one frame → reads 16'h0000 with frame_start = 1.
